// File: rtl/serial_order_merger.sv
// rtl/serial_order_merger.sv - merges tagged lanes into one stream in strict serial order
module serial_order_merger #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_INPUTS   = 4,
  parameter int  SERIAL_WIDTH = 8,
  parameter int  STALL_LIMIT  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  data_t                   in_data  [NUM_INPUTS],
  input  logic [SERIAL_WIDTH-1:0] in_tag   [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0]   in_keep,
  input  logic [NUM_INPUTS-1:0]   in_last,
  input  logic [NUM_INPUTS-1:0]   in_valid,
  output logic [NUM_INPUTS-1:0]   in_ready,
  output data_t                   out_data,
  output logic [SERIAL_WIDTH-1:0] out_tag,
  output logic                    out_keep,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clr_err,
  output logic                    err_stall,
  output logic                    err_dup,
  output logic [31:0]             beat_count
);

  localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  logic [SERIAL_WIDTH-1:0] exp_serial;
  logic [NUM_INPUTS-1:0]   match;
  logic [SEL_W-1:0]        sel;
  logic                    any;
  logic                    dup;
  logic                    load;
  logic                    stall_inc;
  logic [CNT_W-1:0]        stall_cnt;

  always_comb begin
    match = '0;
    sel   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      match[i] = in_valid[i] && (in_tag[i] == exp_serial);
    end
    // Descending scan so the lowest matching lane is the last one written.
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (match[i]) sel = SEL_W'(i);
    end
    any       = |match;
    dup       = |(match & (match - NUM_INPUTS'(1)));
    load      = rst_n && any && (!out_valid || out_ready);
    in_ready  = load ? (NUM_INPUTS'(1) << sel) : '0;
    stall_inc = (|in_valid) && !any;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_serial <= '0;
      out_valid  <= 1'b0;
      beat_count <= '0;
    end else if (load) begin
      exp_serial <= exp_serial + SERIAL_WIDTH'(1);
      out_valid  <= 1'b1;
      beat_count <= beat_count + 32'd1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Payload registers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (load) begin
      out_data <= in_data[sel];
      out_tag  <= in_tag[sel];
      out_keep <= in_keep[sel];
      out_last <= in_last[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_err || load || !(|in_valid)) begin
      stall_cnt <= '0;
    end else if (stall_inc && stall_cnt != CNT_W'(STALL_LIMIT)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Set terms are tested before clear so a simultaneous event wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_stall <= 1'b0;
      err_dup   <= 1'b0;
    end else begin
      if (stall_inc && stall_cnt == CNT_W'(STALL_LIMIT - 1)) err_stall <= 1'b1;
      else if (clr_err)                                      err_stall <= 1'b0;
      if (dup)          err_dup <= 1'b1;
      else if (clr_err) err_dup <= 1'b0;
    end
  end

endmodule
